// File: rtl/fetch_queue.sv
// Fetch stage: owns the fetch PC, reads InstMemory combinationally and buffers
// {pc, inst} pairs in a small FIFO so decode can stall without re-fetching.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic                     clk,
   input  logic                     reset,
   output logic [31:0]              imem_addr,
   input  logic [31:0]              imem_dout,
   input  logic                     redirect_valid,
   input  logic [31:0]              redirect_pc,
   input  logic                     halt,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [31:0]              out_inst,
   output logic [31:0]              out_pc,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = PW + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [CW-1:0] count_q, count_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   pc_mem_q   [DEPTH];
   logic [31:0]   pc_mem_d   [DEPTH];
   logic [31:0]   inst_mem_q [DEPTH];
   logic [31:0]   inst_mem_d [DEPTH];
   logic          empty, push, pop;

   // Handshake: an entry transfers to decode on a cycle where out_valid and
   // out_ready are both high; out_valid never depends on out_ready.
   always_comb begin
      empty      = (count_q == '0);
      pop        = ~empty & out_ready & ~redirect_valid;
      push       = ~redirect_valid & ~halt & ((count_q != DEPTH_C) | pop);
      rd_d       = rd_q;
      wr_d       = wr_q;
      count_d    = count_q;
      fetch_pc_d = fetch_pc_q;
      pc_mem_d   = pc_mem_q;
      inst_mem_d = inst_mem_q;
      if (redirect_valid) begin
         rd_d       = '0;
         wr_d       = '0;
         count_d    = '0;
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else begin
         if (push) begin
            pc_mem_d[wr_q]   = fetch_pc_q;
            inst_mem_d[wr_q] = imem_dout;
            wr_d             = wr_q + PW'(1);
            fetch_pc_d       = fetch_pc_q + 32'd4;
         end
         if (pop) begin
            rd_d = rd_q + PW'(1);
         end
         // Simultaneous push and pop (including when full) leaves count unchanged.
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q       <= '0;
         wr_q       <= '0;
         count_q    <= '0;
         fetch_pc_q <= RESET_PC;
         for (int i = 0; i < DEPTH; i++) begin
            pc_mem_q[i]   <= '0;
            inst_mem_q[i] <= '0;
         end
      end else begin
         rd_q       <= rd_d;
         wr_q       <= wr_d;
         count_q    <= count_d;
         fetch_pc_q <= fetch_pc_d;
         pc_mem_q   <= pc_mem_d;
         inst_mem_q <= inst_mem_d;
      end
   end

   assign imem_addr = fetch_pc_q;
   assign out_valid = ~empty & ~redirect_valid;
   assign out_pc    = empty ? 32'h0 : pc_mem_q[rd_q];
   assign out_inst  = empty ? 32'h0 : inst_mem_q[rd_q];
   assign count     = count_q;

endmodule
